// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - divisor request handshake bundle for clk_div_prog
interface clk_div_prog_if #(
    parameter int DIV_W = 8
);
    logic [DIV_W-1:0] div;
    logic             div_vld;
    logic             div_rdy;
    logic             div_err;

    modport master (
        output div,
        output div_vld,
        input  div_rdy,
        input  div_err
    );

    modport slave (
        input  div,
        input  div_vld,
        output div_rdy,
        output div_err
    );
endinterface

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - run-time programmable 50% duty clock divider (optional o_tick under CLK_DIV_PROG_TICK_EN)
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    clk_div_prog_if.slave  req,
    output logic           o_busy,
`ifdef CLK_DIV_PROG_TICK_EN
    output logic           o_tick,
`endif
    output logic           o_clk
);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] cnt;
    logic             pend;
    logic             pos_q;
    logic             neg_q;
    logic             busy_q;
    logic             err_q;
    logic             tick_q;

    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic             pos_nxt;
    logic             busy_nxt;
    logic             tick_nxt;
    logic             boundary;
    logic             accept;
    logic             reject;

    // Next counter/divisor: a pending divisor only takes effect at a period
    // boundary, so the period that follows is counted entirely with the new N.
    always_comb begin
        boundary = (cnt == div_q - ONE);
        accept   = req.div_vld & ~pend & (req.div >= TWO);
        reject   = req.div_vld & ~pend & (req.div < TWO);
        cnt_nxt  = cnt + ONE;
        div_nxt  = div_q;
        busy_nxt = 1'b1;
        tick_nxt = 1'b0;
        if (boundary) begin
            if (pend) begin
                div_nxt = pend_div;
            end
            if (i_en) begin
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
            end else begin
                cnt_nxt  = div_nxt - ONE;
                busy_nxt = 1'b0;
            end
        end
        pos_nxt = busy_nxt & (cnt_nxt < (div_nxt >> 1));
    end

    // Rising-edge state: counter, high phase, handshake bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_q    <= DEF_DIV;
            pend_div <= DEF_DIV;
            pend     <= 1'b0;
            cnt      <= DEF_DIV - ONE;
            pos_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            div_q  <= div_nxt;
            pos_q  <= pos_nxt;
            busy_q <= busy_nxt;
            err_q  <= reject;
            tick_q <= tick_nxt;
            if (boundary && pend) begin
                pend <= 1'b0;
            end
            if (accept) begin
                pend     <= 1'b1;
                pend_div <= req.div;
            end
        end
    end

    // Falling-edge extension adds the extra half cycle that makes odd N 50%.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q & div_q[0];
        end
    end

    // Reset gates the output directly so it drops without waiting for an edge.
    assign o_clk       = (pos_q | neg_q) & ~i_rst;
    assign o_busy      = busy_q;
    assign req.div_rdy = ~pend;
    assign req.div_err = err_q;

`ifdef CLK_DIV_PROG_TICK_EN
    assign o_tick = tick_q;
`else
    logic unused_tick;
    assign unused_tick = tick_q;
`endif
endmodule
